// File: rtl/eaglesong_coefficients.sv
// ----------------------------------------------------------------------------
// eaglesong_coefficients
//
// Rotation-coefficient ROM for the Eaglesong circulant-multiplication step.
// The table holds 48 five-bit coefficients, 16 rows of 3. Index i = 3*row + k.
// The index also feeds a sticky monitor that records any out-of-range index
// it samples.
//
// Ports
//   clk                    in   1  system clock, rising edge active
//   reset                  in   1  synchronous, active-high reset
//   index_to_request       in   7  coefficient index, legal range 0..47
//   requested_coefficient  out  5  coefficient value; 0 for indices 48..127
//   index_valid            out  1  1 when index_to_request <= 47
//   oob_seen               out  1  sticky flag, set when an illegal index is
//                                  sampled; only reset clears it
//
// Configuration
//   EAGLESONG_COEFF_PIPE_EN  When this is undefined (the default), the
//       coefficient and valid outputs are combinational.
//       When it is defined, both outputs are registered with one cycle of
//       latency, and reset forces them to 0. oob_seen is the same in both
//       builds.
// ----------------------------------------------------------------------------
module eaglesong_coefficients (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] index_to_request,
    output logic [4:0] requested_coefficient,
    output logic       index_valid,
    output logic       oob_seen
);

    logic [4:0] w_coefficient;
    logic       w_valid;
    logic       r_oob_seen;

    assign w_valid = (index_to_request < 7'd48);

    // The k=0 entry of every row is 0, and every out-of-range index also
    // returns 0. Both cases use the default assignment, so only the k=1 and
    // k=2 entries are listed below.
    always_comb begin
        // NOTE: assign the default before the case. Without it, a case arm
        // that is missed would infer a latch, and an index that is not listed
        // could produce X.
        w_coefficient = 5'd0;
        case (index_to_request)
            7'd1:  w_coefficient = 5'd2;
            7'd2:  w_coefficient = 5'd4;
            7'd4:  w_coefficient = 5'd13;
            7'd5:  w_coefficient = 5'd22;
            7'd7:  w_coefficient = 5'd4;
            7'd8:  w_coefficient = 5'd19;
            7'd10: w_coefficient = 5'd3;
            7'd11: w_coefficient = 5'd14;
            7'd13: w_coefficient = 5'd27;
            7'd14: w_coefficient = 5'd31;
            7'd16: w_coefficient = 5'd3;
            7'd17: w_coefficient = 5'd8;
            7'd19: w_coefficient = 5'd17;
            7'd20: w_coefficient = 5'd26;
            7'd22: w_coefficient = 5'd3;
            7'd23: w_coefficient = 5'd12;
            7'd25: w_coefficient = 5'd18;
            7'd26: w_coefficient = 5'd22;
            7'd28: w_coefficient = 5'd12;
            7'd29: w_coefficient = 5'd18;
            7'd31: w_coefficient = 5'd4;
            7'd32: w_coefficient = 5'd7;
            7'd34: w_coefficient = 5'd4;
            7'd35: w_coefficient = 5'd31;
            7'd37: w_coefficient = 5'd12;
            7'd38: w_coefficient = 5'd27;
            7'd40: w_coefficient = 5'd7;
            7'd41: w_coefficient = 5'd17;
            7'd43: w_coefficient = 5'd7;
            7'd44: w_coefficient = 5'd8;
            7'd46: w_coefficient = 5'd1;
            7'd47: w_coefficient = 5'd13;
            default: w_coefficient = 5'd0;
        endcase
    end

    // The monitor looks at the raw index, not a pipelined copy. That way an
    // illegal index is flagged on the edge where it is present in both builds.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for every clocked register, so
        // that all flops sample their inputs before any of them updates.
        if (reset) begin
            r_oob_seen <= 1'b0;
        end else if (!w_valid) begin
            r_oob_seen <= 1'b1;
        end
    end

    assign oob_seen = r_oob_seen;

`ifdef EAGLESONG_COEFF_PIPE_EN
    logic [4:0] r_coefficient;
    logic       r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coefficient <= 5'd0;
            r_valid       <= 1'b0;
        end else begin
            r_coefficient <= w_coefficient;
            r_valid       <= w_valid;
        end
    end

    assign requested_coefficient = r_coefficient;
    assign index_valid           = r_valid;
`else
    assign requested_coefficient = w_coefficient;
    assign index_valid           = w_valid;
`endif

endmodule

// File: tb/tb_eaglesong_coefficients.sv
// ----------------------------------------------------------------------------
// tb_eaglesong_coefficients
//
// Self-checking bench for eaglesong_coefficients. The reference model holds
// the coefficient table as 16 row triples and looks entries up by row = i/3
// and k = i%3. It tracks the sticky flag as "was an illegal index seen since
// the last reset". Inputs change 1 ns after the falling edge. A compare
// process checks the DUT against the model on every falling edge. Directed
// tests cover the example values and the boundary cases. Randomized traffic
// covers the rest. It works in both builds (EAGLESONG_COEFF_PIPE_EN).
// ----------------------------------------------------------------------------
module tb_eaglesong_coefficients;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] index_to_request;
    logic [4:0] requested_coefficient;
    logic       index_valid;
    logic       oob_seen;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    eaglesong_coefficients dut (
        .clk                   (clk),
        .reset                 (reset),
        .index_to_request      (index_to_request),
        .requested_coefficient (requested_coefficient),
        .index_valid           (index_valid),
        .oob_seen              (oob_seen)
    );

    // ---------------- reference model ----------------
    int rows [16][3] = '{
        '{0, 2, 4},   '{0, 13, 22}, '{0, 4, 19},  '{0, 3, 14},
        '{0, 27, 31}, '{0, 3, 8},   '{0, 17, 26}, '{0, 3, 12},
        '{0, 18, 22}, '{0, 12, 18}, '{0, 4, 7},   '{0, 4, 31},
        '{0, 12, 27}, '{0, 7, 17},  '{0, 7, 8},   '{0, 1, 13}
    };

    function automatic int model_coef(input int idx);
        if (idx >= 48) return 0;
        return rows[idx / 3][idx % 3];
    endfunction

    function automatic bit model_valid(input int idx);
        return (idx < 48);
    endfunction

    bit m_oob;
    int m_coef_q;
    bit m_valid_q;

    always @(posedge clk) begin
        if (reset) begin
            m_oob     = 1'b0;
            m_coef_q  = 0;
            m_valid_q = 1'b0;
        end else begin
            if (!model_valid(int'(index_to_request))) m_oob = 1'b1;
            m_coef_q  = model_coef(int'(index_to_request));
            m_valid_q = model_valid(int'(index_to_request));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
`ifdef EAGLESONG_COEFF_PIPE_EN
            check("cyc_coef", 32'(requested_coefficient), 32'(m_coef_q));
            check("cyc_valid", 32'(index_valid), 32'(m_valid_q));
`else
            check("cyc_coef", 32'(requested_coefficient), 32'(model_coef(int'(index_to_request))));
            check("cyc_valid", 32'(index_valid), 32'(model_valid(int'(index_to_request))));
`endif
            check("cyc_oob", 32'(oob_seen), 32'(m_oob));
        end
    end

    task automatic set_idx(input int v);
        @(negedge clk);
        #1;
        index_to_request = 7'(v);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        index_to_request = 7'd0;
        after_edge();
        after_edge();
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Pin the model itself to hand-derived values.
        check("model_idx1", 32'(model_coef(1)), 32'd2);
        check("model_idx14", 32'(model_coef(14)), 32'd31);
        check("model_idx47", 32'(model_coef(47)), 32'd13);
        check("model_idx35", 32'(model_coef(35)), 32'd31);
        check("model_idx50", 32'(model_coef(50)), 32'd0);

        check("rst_oob", 32'(oob_seen), 32'd0);

`ifdef EAGLESONG_COEFF_PIPE_EN
        check("rst_coef", 32'(requested_coefficient), 32'd0);
        check("rst_valid", 32'(index_valid), 32'd0);
        set_idx(14);
        check("pipe_14_before", 32'(requested_coefficient), 32'd0);
        after_edge();
        check("pipe_14_after", 32'(requested_coefficient), 32'd31);
        check("pipe_14_valid", 32'(index_valid), 32'd1);
        set_idx(47);
        check("pipe_47_before", 32'(requested_coefficient), 32'd31);
        after_edge();
        check("pipe_47_after", 32'(requested_coefficient), 32'd13);
        @(negedge clk);
        reset = 1'b1;
        after_edge();
        check("pipe_rst_coef", 32'(requested_coefficient), 32'd0);
        check("pipe_rst_valid", 32'(index_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`else
        set_idx(0);
        check("idx0_coef", 32'(requested_coefficient), 32'd0);
        check("idx0_valid", 32'(index_valid), 32'd1);
        set_idx(1);
        check("idx1_coef", 32'(requested_coefficient), 32'd2);
        set_idx(14);
        check("idx14_coef", 32'(requested_coefficient), 32'd31);
        set_idx(47);
        check("idx47_coef", 32'(requested_coefficient), 32'd13);
        check("idx47_valid", 32'(index_valid), 32'd1);
        set_idx(50);
        check("idx50_coef", 32'(requested_coefficient), 32'd0);
        check("idx50_valid", 32'(index_valid), 32'd0);
        check("oob_before_edge", 32'(oob_seen), 32'd0);
        set_idx(127);
        check("idx127_coef", 32'(requested_coefficient), 32'd0);
        check("idx127_valid", 32'(index_valid), 32'd0);
        after_edge();
        check("oob_set", 32'(oob_seen), 32'd1);
        set_idx(5);
        check("idx5_coef", 32'(requested_coefficient), 32'd22);
        after_edge();
        check("oob_sticky", 32'(oob_seen), 32'd1);

        // A full sweep of the index range, with no clock dependence.
        for (int i = 0; i < 128; i++) begin
            index_to_request = 7'(i);
            #1;
            check("sweep_coef", 32'(requested_coefficient), 32'(model_coef(i)));
            check("sweep_valid", 32'(index_valid), 32'(model_valid(i)));
            check("sweep_noxz", 32'($isunknown({requested_coefficient, index_valid})), 32'd0);
            if (i < 48 && (i % 3) == 0)
                check("sweep_k0_zero", 32'(requested_coefficient), 32'd0);
        end
        set_idx(4);
        check("idx4_coef", 32'(requested_coefficient), 32'd13);
        set_idx(8);
        check("idx8_coef", 32'(requested_coefficient), 32'd19);
        set_idx(35);
        check("idx35_coef", 32'(requested_coefficient), 32'd31);
        set_idx(46);
        check("idx46_coef", 32'(requested_coefficient), 32'd1);
`endif

        // Reset takes priority over an illegal index on the same edge.
        @(negedge clk);
        #1;
        index_to_request = 7'd60;
        reset            = 1'b1;
        after_edge();
        check("oob_rst_priority", 32'(oob_seen), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        after_edge();
        check("oob_reset_then_set", 32'(oob_seen), 32'd1);

        // Randomized traffic: mostly legal indices with occasional resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 9) == 0)
                index_to_request = 7'($urandom_range(48, 127));
            else
                index_to_request = 7'($urandom_range(0, 47));
            reset = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        after_edge();
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
